multicycle_control_fsm: RTL and testbench



---
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// The master side supplies the opcode and memory handshake; the slave side drives selects and strobes.
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       instr_done;
  logic       err;

  modport master (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state,
           instr_done, err
  );

  modport slave (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state,
           instr_done, err
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore-style sequencer for the multicycle CPU datapath: fetch/decode/execute/memory/writeback
// with memory-ready stalls, a not-ready timeout, and a sticky trap on illegal opcodes.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 into PC on ready
// DECODE | latch opcode, branch target into ALUOut
// MEMADR | base + offset address for LW/SW
// MEMRD  | data read at ALUOut
// MEMWB  | MDR into rt
// MEMWR  | data write at ALUOut
// EXEC   | R-format ALU op
// RWB    | ALUOut into rd
// BRANCH | compare and conditional PC load
// JUMP   | jump target into PC
// ADDIEX | A + sign-extended immediate
// ADDIWB | ALUOut into rt
// TRAP   | illegal opcode or memory timeout, held until reset
module multicycle_control_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_control_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [5:0]       opcode_q, opcode_d;
  logic             err_q, err_d;

  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       timed_out, in_mem_state;

  assign timed_out    = (wait_cnt_q == TIMEOUT_CNT);
  assign in_mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      opcode_q   <= opcode_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready)  state_d = DECODE;
        else if (timed_out) state_d = TRAP;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only LW/SW can reach here, so anything else means a corrupted latch.
        if (opcode_q == OP_LW)      state_d = MEMRD;
        else if (opcode_q == OP_SW) state_d = MEMWR;
        else                        state_d = TRAP;
      end
      MEMRD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        if (bus.mem_ready)  state_d = MEMWB;
        else if (timed_out) state_d = TRAP;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (timed_out) begin
          state_d = TRAP;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = RWB;
      end
      RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // Counter runs only while stalling in place; any entry or ready cycle restarts it at zero.
  always_comb begin
    wait_cnt_d = '0;
    if (in_mem_state && (state_d == state_q) && !bus.mem_ready)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign opcode_d = (state_q == DECODE) ? bus.opcode : opcode_q;
  assign err_d    = err_q | (state_d == TRAP);

  // Strobes are gated by rst_n so an abandoned instruction cannot write while reset is held.
  assign bus.PCWrite     = pc_write      & rst_n;
  assign bus.PCWriteCond = pc_write_cond & rst_n;
  assign bus.IRWrite     = ir_write      & rst_n;
  assign bus.RegWrite    = reg_write     & rst_n;
  assign bus.MemWrite    = mem_write     & rst_n;
  assign bus.instr_done  = instr_done    & rst_n;

  assign bus.IorD     = ior_d;
  assign bus.MemRead  = mem_read;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.RegDst   = reg_dst;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.PCSource = pc_source;
  assign bus.state    = state_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle sequencer: state sequences, strobes, stalls, timeout,
// illegal opcode trap and reset during a memory write.
module tb_multicycle_control_fsm;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'd0;
    #3;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    checks++; if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWriteCond, bus.instr_done} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 000000",
        {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWriteCond, bus.instr_done});
    end
    next_cycle();
    rst_n = 1'b1;
    #2;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL release_state got %0d want 0", bus.state); end
    checks++; if ({bus.MemRead, bus.IRWrite, bus.PCWrite, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource} !== 11'b111_00_01_00_00) begin
      errors++; $display("FAIL fetch_outputs got %b want 11100010000",
        {bus.MemRead, bus.IRWrite, bus.PCWrite, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource});
    end
    apply_reset();
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    int done_cnt = 0;
    bus.opcode = 6'd0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1;
      #2;
      checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL rtype_state step %0d got %0d want %0d", i, bus.state, exp_st[i]); end
      checks++; if (bus.RegWrite !== (i == 3) || bus.RegDst !== (i == 3)) begin
        errors++; $display("FAIL rtype_regwrite step %0d got %b%b want %0d%0d", i, bus.RegWrite, bus.RegDst, i == 3, i == 3);
      end
      if (i == 1) begin
        checks++; if (bus.ALUSrcB !== 2'b11 || bus.ALUSrcA !== 1'b0) begin errors++; $display("FAIL decode_alusrc got %b/%b want 0/11", bus.ALUSrcA, bus.ALUSrcB); end
      end
      if (i == 2) begin
        checks++; if (bus.ALUOp !== 2'b10 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b00) begin
          errors++; $display("FAIL exec_alu got %b/%b/%b want 1/00/10", bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp);
        end
      end
      done_cnt += int'(bus.instr_done);
      next_cycle();
    end
    #2;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rtype_done_count got %0d want 1", done_cnt); end
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL rtype_return got %0d want 0", bus.state); end
  endtask

  task automatic test_lw_stalls();
    logic [3:0] exp_st [8] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4};
    logic       rdy    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       exp_ir [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.opcode = 6'd35;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #2;
      checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL lw_state step %0d got %0d want %0d", i, bus.state, exp_st[i]); end
      checks++; if (bus.IRWrite !== exp_ir[i]) begin errors++; $display("FAIL lw_irwrite step %0d got %b want %b", i, bus.IRWrite, exp_ir[i]); end
      checks++; if (bus.RegWrite !== (i == 7) || bus.MemtoReg !== (i == 7)) begin
        errors++; $display("FAIL lw_writeback step %0d got %b%b want %0d%0d", i, bus.RegWrite, bus.MemtoReg, i == 7, i == 7);
      end
      if (i == 5) begin
        checks++; if (bus.MemRead !== 1'b1 || bus.IorD !== 1'b1) begin errors++; $display("FAIL memrd_outputs got %b%b want 11", bus.MemRead, bus.IorD); end
      end
      next_cycle();
    end
    #2;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL lw_return got %0d want 0", bus.state); end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic       rdy    [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.opcode = 6'd43;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy[i];
      #2;
      checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL sw_state step %0d got %0d want %0d", i, bus.state, exp_st[i]); end
      checks++; if (bus.MemWrite !== (i >= 3)) begin errors++; $display("FAIL sw_memwrite step %0d got %b want %0d", i, bus.MemWrite, i >= 3); end
      checks++; if (bus.instr_done !== (i == 4)) begin errors++; $display("FAIL sw_done step %0d got %b want %0d", i, bus.instr_done, i == 4); end
      next_cycle();
    end
    #2;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL sw_return got %0d want 0", bus.state); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
    logic [5:0] ops    [6] = '{6'd4, 6'd4, 6'd4, 6'd2, 6'd2, 6'd2};
    int done_cnt = 0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.opcode = ops[i];
      #2;
      checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL bj_state step %0d got %0d want %0d", i, bus.state, exp_st[i]); end
      if (i == 2) begin
        checks++; if (bus.PCWriteCond !== 1'b1 || bus.PCSource !== 2'b01 || bus.ALUOp !== 2'b01 || bus.PCWrite !== 1'b0) begin
          errors++; $display("FAIL branch_outputs got cond=%b src=%b op=%b pcw=%b want 1/01/01/0", bus.PCWriteCond, bus.PCSource, bus.ALUOp, bus.PCWrite);
        end
      end
      if (i == 5) begin
        checks++; if (bus.PCWrite !== 1'b1 || bus.PCSource !== 2'b10 || bus.PCWriteCond !== 1'b0) begin
          errors++; $display("FAIL jump_outputs got pcw=%b src=%b cond=%b want 1/10/0", bus.PCWrite, bus.PCSource, bus.PCWriteCond);
        end
      end
      done_cnt += int'(bus.instr_done);
      next_cycle();
    end
    #2;
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL bj_done_count got %0d want 2", done_cnt); end
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL bj_return got %0d want 0", bus.state); end
  endtask

  task automatic test_addi();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
    bus.opcode    = 6'd8;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL addi_state step %0d got %0d want %0d", i, bus.state, exp_st[i]); end
      checks++; if (bus.RegWrite !== (i == 3) || bus.RegDst !== 1'b0 || bus.MemtoReg !== 1'b0) begin
        errors++; $display("FAIL addi_regwrite step %0d got %b%b%b want %0d00", i, bus.RegWrite, bus.RegDst, bus.MemtoReg, i == 3);
      end
      if (i == 2) begin
        checks++; if (bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b10) begin errors++; $display("FAIL addiex_alusrc got %b/%b want 1/10", bus.ALUSrcA, bus.ALUSrcB); end
      end
      next_cycle();
    end
  endtask

  task automatic test_fetch_timeout();
    apply_reset();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #2;
      checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL timeout_wait cycle %0d got %0d want 0", i, bus.state); end
      next_cycle();
    end
    #2;
    checks++; if (bus.state !== 4'd12) begin errors++; $display("FAIL timeout_trap got %0d want 12", bus.state); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", bus.err); end
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      next_cycle();
      #2;
      checks++; if (bus.err !== 1'b1 || bus.state !== 4'd12) begin
        errors++; $display("FAIL trap_sticky cycle %0d got err=%b state=%0d want 1/12", i, bus.err, bus.state);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== 4'd0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL trap_reset got state=%0d err=%b want 0/0", bus.state, bus.err);
    end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_illegal_opcode();
    apply_reset();
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'd63;
    next_cycle();
    #2;
    checks++; if (bus.state !== 4'd1 || bus.err !== 1'b0) begin errors++; $display("FAIL illegal_decode got state=%0d err=%b want 1/0", bus.state, bus.err); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #2;
      checks++; if (bus.state !== 4'd12 || bus.err !== 1'b1) begin errors++; $display("FAIL illegal_trap cycle %0d got state=%0d err=%b want 12/1", i, bus.state, bus.err); end
      checks++; if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin
        errors++; $display("FAIL illegal_strobes cycle %0d got %b%b%b want 000", i, bus.RegWrite, bus.MemWrite, bus.PCWrite);
      end
    end
    apply_reset();
  endtask

  task automatic test_reset_during_memwr();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    bus.opcode    = 6'd43;
    bus.mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    bus.mem_ready = 1'b0;
    #2;
    checks++; if (bus.state !== 4'd5 || bus.MemWrite !== 1'b1) begin errors++; $display("FAIL memwr_pre got state=%0d mw=%b want 5/1", bus.state, bus.MemWrite); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== 4'd0 || bus.MemWrite !== 1'b0) begin errors++; $display("FAIL memwr_abort got state=%0d mw=%b want 0/0", bus.state, bus.MemWrite); end
    next_cycle();
    rst_n         = 1'b1;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL post_reset_state step %0d got %0d want %0d", i, bus.state, exp_st[i]); end
      next_cycle();
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stalls();
    test_sw();
    test_back_to_back();
    test_addi();
    test_fetch_timeout();
    test_illegal_opcode();
    test_reset_during_memwr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
